// File: rtl/data_mem_pkg.sv
// data_mem_pkg
// Shared definitions for the data memory responder:
//   - state_e    : responder FSM states (idle, waiting on latency, responding)
//   - WORD_BYTES : bytes per stored word
//   - field widths for data, address, byte enables, error flag, latency counter
//   - apply_be   : merges store data into an existing word under byte enables
package data_mem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int BE_W       = WORD_BYTES;
  localparam int ERR_W      = 1;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Byte-lane merge: lane i of the result comes from new_word when be[i] is set.
  function automatic logic [DATA_W-1:0] apply_be(input logic [DATA_W-1:0] old_word,
                                                 input logic [DATA_W-1:0] new_word,
                                                 input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// data_mem_array
// Word-organised storage with a synchronous byte-enable write port and a
// combinational read port sharing one index. Contents are not reset.
// Ports:
//   clk    : write clock
//   we     : commit a write at the next rising edge
//   idx    : word index for both read and write
//   wdata  : store data
//   be     : byte-lane enables for the write
//   rdata  : word currently at idx
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] words [DEPTH_WORDS];

  // Byte-enable write; untouched lanes keep their previous value.
  always_ff @(posedge clk) begin
    if (we) begin
      words[idx] <= apply_be(words[idx], wdata, be);
    end
  end

  assign rdata = words[idx];

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Single-outstanding load/store responder with a fixed request-to-response
// latency. A request is captured in IDLE, a counter covers the latency, and
// the memory is touched only on the edge that enters RESP.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid / req_ready    : request handshake
//   req_we, req_addr,
//   req_wdata, req_be        : request fields (store flag, byte address, data, lanes)
//   resp_valid / resp_ready  : response handshake
//   resp_rdata, resp_err     : load data (0 on stores/errors), error flag
// The storage instance is named d_mem.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int              IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0]     ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'(WORD_BYTES);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic            LAT_IS_ONE = (LATENCY == 32'sd1);

  state_e            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [BE_W-1:0]   be_r;
  logic              req_ready_r;
  logic              resp_valid_r;
  logic [DATA_W-1:0] resp_rdata_r;
  logic [ERR_W-1:0]  resp_err_r;

  logic              acc_we_s;
  logic [ADDR_W-1:0] acc_addr_s;
  logic [DATA_W-1:0] acc_wdata_s;
  logic [BE_W-1:0]   acc_be_s;
  logic              err_s;
  logic              go_resp_s;
  logic              mem_we_s;
  logic [IDX_W-1:0]  idx_s;
  logic [DATA_W-1:0] mem_rdata_s;
  logic [DATA_W-1:0] resp_data_s;

  // Access fields: with LATENCY=1 the access happens on the capture edge, so
  // the live request is used in IDLE; otherwise the captured copy is used.
  always_comb begin
    acc_we_s    = 1'b0;
    acc_addr_s  = 32'd0;
    acc_wdata_s = 32'd0;
    acc_be_s    = 4'd0;
    if (state_r == ST_IDLE) begin
      acc_we_s    = req_we;
      acc_addr_s  = req_addr;
      acc_wdata_s = req_wdata;
      acc_be_s    = req_be;
    end else begin
      acc_we_s    = we_r;
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
      acc_be_s    = be_r;
    end
  end

  // Error decode, RESP-entry detection and the single memory access strobe.
  always_comb begin
    err_s = (acc_addr_s[1:0] != 2'b00) || ({1'b0, acc_addr_s} >= ADDR_LIMIT);
    idx_s = acc_addr_s[IDX_W+1:2];
    case (state_r)
      ST_IDLE: go_resp_s = req_valid && LAT_IS_ONE;
      ST_WAIT: go_resp_s = (cnt_r == CNT_ONE);
      ST_RESP: go_resp_s = 1'b0;
      default: go_resp_s = 1'b0;
    endcase
    // Reset on the commit edge must drop the pending store.
    mem_we_s = go_resp_s && acc_we_s && !err_s && !rst;
    if (err_s || acc_we_s) begin
      resp_data_s = 32'd0;
    end else begin
      resp_data_s = mem_rdata_s;
    end
  end

  data_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) d_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .idx   (idx_s),
    .wdata (acc_wdata_s),
    .be    (acc_be_s),
    .rdata (mem_rdata_s)
  );

  // Responder FSM: capture, latency count, response hold and release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      we_r         <= 1'b0;
      addr_r       <= 32'd0;
      wdata_r      <= 32'd0;
      be_r         <= 4'd0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            we_r        <= req_we;
            addr_r      <= req_addr;
            wdata_r     <= req_wdata;
            be_r        <= req_be;
            req_ready_r <= 1'b0;
            if (go_resp_s) begin
              state_r      <= ST_RESP;
              cnt_r        <= {CNT_W{1'b0}};
              resp_valid_r <= 1'b1;
              resp_rdata_r <= resp_data_s;
              resp_err_r   <= err_s;
            end else begin
              state_r <= ST_WAIT;
              cnt_r   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (go_resp_s) begin
            state_r      <= ST_RESP;
            cnt_r        <= {CNT_W{1'b0}};
            resp_valid_r <= 1'b1;
            resp_rdata_r <= resp_data_s;
            resp_err_r   <= err_s;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_RESP: begin
          // Response fields hold until taken; req_ready only returns in IDLE.
          if (resp_ready) begin
            state_r      <= ST_IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          cnt_r        <= {CNT_W{1'b0}};
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          resp_rdata_r <= 32'd0;
          resp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Four responders (LATENCY 1..4, DEPTH_WORDS 64) share clock and reset.
// A per-instance word array models memory; expected data, error and
// latency come from the load/store rules applied to that array.
module tb_data_mem_responder;

  localparam int NU = 4;

  logic        clk;
  logic        rst;
  logic        req_valid  [NU];
  logic        req_ready  [NU];
  logic        req_we     [NU];
  logic [31:0] req_addr   [NU];
  logic [31:0] req_wdata  [NU];
  logic [3:0]  req_be     [NU];
  logic        resp_valid [NU];
  logic        resp_ready [NU];
  logic [31:0] resp_rdata [NU];
  logic        resp_err   [NU];

  logic [31:0] model_mem [NU][64];
  int checks;
  int errors;

  for (genvar g = 0; g < NU; g++) begin : gen_dut
    data_mem_responder #(
      .DEPTH_WORDS (64),
      .LATENCY     (g + 1)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_be     (req_be[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g])
    );
  end

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete transaction on unit u, checked against the model.
  task automatic do_txn(input int u, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int hold, output logic [31:0] rdata);
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] held;
    int          lat;
    int          w;
    exp_err   = (addr % 4 != 0) || (addr >= 32'd256);
    w         = int'(addr / 4);
    exp_rdata = (exp_err || we) ? 32'd0 : model_mem[u][w];
    if (!exp_err && we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) model_mem[u][w][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    chk("req_ready_idle", 32'(req_ready[u]), 32'd1);
    req_valid[u] = 1'b1;
    req_we[u]    = we;
    req_addr[u]  = addr;
    req_wdata[u] = wdata;
    req_be[u]    = be;
    tick();
    // Garbage on the request bus after capture must be ignored.
    req_valid[u] = 1'b1;
    req_we[u]    = 1'($urandom);
    req_addr[u]  = $urandom;
    req_wdata[u] = $urandom;
    req_be[u]    = 4'($urandom);
    lat = 1;
    while (resp_valid[u] !== 1'b1 && lat < 40) begin
      chk("req_ready_wait", 32'(req_ready[u]), 32'd0);
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'(u + 1));
    chk("resp_err", 32'(resp_err[u]), 32'(exp_err));
    chk("resp_rdata", resp_rdata[u], exp_rdata);
    rdata = resp_rdata[u];
    held  = resp_rdata[u];
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", 32'(resp_valid[u]), 32'd1);
      chk("hold_rdata", resp_rdata[u], held);
      chk("hold_ready", 32'(req_ready[u]), 32'd0);
    end
    resp_ready[u] = 1'b1;
    tick();
    resp_ready[u] = 1'b0;
    req_valid[u]  = 1'b0;
    chk("post_valid", 32'(resp_valid[u]), 32'd0);
    chk("post_ready", 32'(req_ready[u]), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] addr;
    int          sel;
    int          u;
    checks = 0;
    errors = 0;
    clk    = 1'b0;
    rst    = 1'b1;
    for (int i = 0; i < NU; i++) begin
      req_valid[i]  = 1'b0;
      req_we[i]     = 1'b0;
      req_addr[i]   = 32'd0;
      req_wdata[i]  = 32'd0;
      req_be[i]     = 4'd0;
      resp_ready[i] = 1'b0;
      for (int j = 0; j < 64; j++) model_mem[i][j] = 32'd0;
    end

    // Reset state.
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < NU; i++) begin
      chk("rst_req_ready", 32'(req_ready[i]), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid[i]), 32'd0);
      chk("rst_resp_rdata", resp_rdata[i], 32'd0);
      chk("rst_resp_err", 32'(resp_err[i]), 32'd0);
    end
    tick();

    // Full-word store then load back.
    do_txn(1, 1'b1, 32'h14, 32'h0000_0010, 4'b1111, 0, rd);
    chk("dmem5", gen_dut[1].u_dut.d_mem.words[5], 32'h0000_0010);
    do_txn(1, 1'b0, 32'h14, 32'h0, 4'b0000, 0, rd);
    chk("load5", rd, 32'h0000_0010);

    // Partial-lane store merges into existing word.
    do_txn(1, 1'b1, 32'h0C, 32'hAABB_CCDD, 4'b1111, 0, rd);
    do_txn(1, 1'b1, 32'h0C, 32'h1122_3344, 4'b0101, 0, rd);
    do_txn(1, 1'b0, 32'h0C, 32'h0, 4'b1111, 0, rd);
    chk("be_merge", rd, 32'hAA22_CC44);

    // No-op store with be=0000.
    do_txn(1, 1'b1, 32'h0C, 32'hFFFF_FFFF, 4'b0000, 0, rd);
    do_txn(1, 1'b0, 32'h0C, 32'h0, 4'b0000, 0, rd);
    chk("be_zero", rd, 32'hAA22_CC44);

    // Misaligned and out-of-range accesses; 0x100 aliases word 0 in its low bits.
    do_txn(1, 1'b1, 32'h00, 32'h5A5A_0101, 4'b1111, 0, rd);
    do_txn(1, 1'b0, 32'h16, 32'h0, 4'b1111, 0, rd);
    do_txn(1, 1'b0, 32'h100, 32'h0, 4'b1111, 0, rd);
    do_txn(1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b1111, 0, rd);
    do_txn(1, 1'b1, 32'h16, 32'hDEAD_BEEF, 4'b1111, 0, rd);
    do_txn(1, 1'b0, 32'h00, 32'h0, 4'b0000, 0, rd);
    chk("oor_no_write", rd, 32'h5A5A_0101);
    do_txn(1, 1'b0, 32'h14, 32'h0, 4'b0000, 0, rd);
    chk("misalign_no_write", rd, 32'h0000_0010);

    // Backpressure held five cycles.
    do_txn(1, 1'b0, 32'h0C, 32'h0, 4'b0000, 5, rd);

    // Latency 1 and 3.
    do_txn(0, 1'b1, 32'h40, 32'h0102_0304, 4'b1111, 1, rd);
    do_txn(0, 1'b0, 32'h40, 32'h0, 4'b0000, 0, rd);
    do_txn(2, 1'b1, 32'hFC, 32'hCAFE_0003, 4'b1111, 0, rd);
    do_txn(2, 1'b0, 32'hFC, 32'h0, 4'b0000, 2, rd);

    // Reset on the would-be commit edge of a LATENCY=4 store.
    do_txn(3, 1'b1, 32'h20, 32'hCAFE_F00D, 4'b1111, 0, rd);
    req_valid[3] = 1'b1;
    req_we[3]    = 1'b1;
    req_addr[3]  = 32'h20;
    req_wdata[3] = 32'h1234_5678;
    req_be[3]    = 4'b1111;
    tick();
    req_valid[3] = 1'b0;
    tick();
    tick();
    chk("abort_pre_valid", 32'(resp_valid[3]), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ready", 32'(req_ready[3]), 32'd1);
    chk("abort_valid", 32'(resp_valid[3]), 32'd0);
    chk("abort_dmem8", gen_dut[3].u_dut.d_mem.words[8], 32'hCAFE_F00D);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort_no_resp", 32'(resp_valid[3]), 32'd0);
    end
    do_txn(3, 1'b0, 32'h20, 32'h0, 4'b0000, 0, rd);
    chk("abort_load", rd, 32'hCAFE_F00D);

    // Randomized traffic across all latencies.
    for (int t = 0; t < 80; t++) begin
      u   = $urandom_range(0, NU - 1);
      sel = $urandom_range(0, 9);
      if (sel < 7) begin
        addr = 32'($urandom_range(0, 63)) * 32'd4;
      end else if (sel == 7) begin
        addr = (32'($urandom_range(0, 63)) * 32'd4) | 32'($urandom_range(1, 3));
      end else begin
        addr = $urandom | 32'h0000_0100;
      end
      do_txn(u, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom),
             $urandom_range(0, 2), rd);
    end

    // Final memory sweep against the model.
    for (int w = 0; w < 64; w++) begin
      chk("sweep_u0", gen_dut[0].u_dut.d_mem.words[w], model_mem[0][w]);
      chk("sweep_u1", gen_dut[1].u_dut.d_mem.words[w], model_mem[1][w]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, meaning number of 32-bit words stored.
REQ-002 Parameter LATENCY, default 2, meaning cycles from request accept to response valid; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_we  input  1  1 = store (sw), 0 = load (lw).
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_be  input  4  byte enables for stores; bit i selects byte lane i, little-endian.
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  initiator accepts response.
REQ-013 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 resp_err  output  1  request was misaligned or out of range.

Function
REQ-015 FSM states: IDLE, WAIT, RESP; exactly one transaction outstanding.
REQ-016 IDLE: req_ready=1; on req_valid&req_ready, capture we/addr/wdata/be and load latency counter with LATENCY-1.
REQ-017 After capture: LATENCY=1 -> RESP next cycle; otherwise -> WAIT.
REQ-018 WAIT: req_ready=0; counter decrements each cycle; transition to RESP in the cycle the counter reaches 1.
REQ-019 Memory access (read sample or write commit) occurs on the WAIT->RESP or IDLE->RESP transition edge, never earlier.
REQ-020 Handshake accepted at cycle N gives resp_valid=1 first at cycle N+LATENCY.
REQ-021 RESP: resp_valid=1, req_ready=0; resp_rdata/resp_err stable while resp_ready=0.
REQ-022 RESP with resp_ready=1: return to IDLE next cycle; no new request accepted in that same cycle.
REQ-023 Word index = req_addr[log2(DEPTH_WORDS)+1:2].
REQ-024 Error when req_addr[1:0]!=0 or word index >= DEPTH_WORDS (req_addr >= 4*DEPTH_WORDS); error suppresses write and forces resp_rdata=0, resp_err=1.
REQ-025 Store writes only lanes with req_be bit set; req_be=0000 is a legal no-op store, resp_err=0.
REQ-026 Load returns full 32-bit word regardless of req_be.
REQ-027 req_* inputs ignored outside IDLE; changes after capture have no effect.

Reset
REQ-028 rst=1 at a clock edge: state IDLE, req_ready=1 in following cycle, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
REQ-029 Reset during WAIT aborts transaction; pending store is not committed.
REQ-030 Reset does not alter memory contents; simulation initial contents all zero.

Structure
REQ-031 Shared package data_mem_pkg holds state enum, WORD_BYTES=4, and error/response field widths.
REQ-032 Storage in one sub-module data_mem_array: synchronous byte-enable write, combinational read, DEPTH_WORDS parameter.
REQ-033 Top holds FSM, latency counter, capture registers, error decode; memory array exposed hierarchically as d_mem for bench inspection.

Verification
REQ-034 Store 0x00000010 to 0x14, be=1111 -> resp_err=0 at N+2; d_mem[5]=0x00000010; load 0x14 returns 0x00000010.
REQ-035 Preload d_mem[3]=0xAABBCCDD; store 0x11223344 to 0x0C be=0101 -> load returns 0xAA22CC44.
REQ-036 Load 0x16 (misaligned) and load 0x100 with DEPTH_WORDS=64 -> resp_err=1, resp_rdata=0; store 0x100 leaves memory unchanged.
REQ-037 resp_ready held 0 for 5 cycles in RESP -> resp_valid, resp_rdata stable, req_ready=0; released -> IDLE next cycle.
REQ-038 LATENCY=4, store accepted, rst asserted in WAIT -> target word unchanged, resp_valid never asserts, req_ready=1 after reset.
REQ-039 LATENCY=1 and LATENCY=3 -> resp_valid rises exactly 1 and 3 cycles after handshake.
